veririsc_controller: RTL and testbench
======================================

# veririsc_controller

- Sequencing control unit of the VeriRISC processor: an 8-phase instruction-cycle state machine.
- Decodes the current phase, the instruction opcode and the accumulator zero flag into the datapath strobes.
- Its `sel` output drives the address multiplexer directly: 1 = program-counter address, 0 = instruction-register operand address.
- Also drives memory read/write, IR/AC/PC load, PC increment, data-bus enable and halt.

## Interface
- No parameters; phase width fixed at 3 bits, opcode width fixed at 3 bits.
- `clk` input 1: sole clock, rising-edge.
- `rst_` input 1: reset, asynchronous, active-low.
- `opcode` input 3: IR opcode field. HLT=0, SKZ=1, ADD=2, AND=3, XOR=4, LDA=5, STO=6, JMP=7.
- `zero` input 1: accumulator-is-zero flag.
- `step` input 1: single-step resume request. Present only with `VERIRISC_CTRL_STEP_EN`.
- `sel` output 1: address mux select (1 = PC, 0 = IR address).
- `rd` output 1: memory read enable.
- `ld_ir` output 1: instruction register load.
- `inc_pc` output 1: PC increment.
- `ld_pc` output 1: PC load (jump).
- `ld_ac` output 1: accumulator load.
- `data_e` output 1: data-bus drive enable for store.
- `wr` output 1: memory write strobe.
- `halt` output 1: processor halted.
- `phase` output 3: current phase, for debug and test.

## Operation
- States: INST_ADDR(0), INST_FETCH(1), INST_LOAD(2), IDLE(3), OP_ADDR(4), OP_FETCH(5), ALU_OP(6), STORE(7), plus a HALTED flag register.
- While not halted, `phase` advances by 1 every clock and wraps from 7 to 0.
- Let ALUOP = ADD|AND|XOR|LDA.
- Outputs are a combinational decode of the registered phase, HALTED, `opcode` and `zero`. Every output not listed for a phase is 0:
  - INST_ADDR: sel=1.
  - INST_FETCH: sel=1, rd=1.
  - INST_LOAD: sel=1, rd=1, ld_ir=1.
  - IDLE: sel=1, rd=1, ld_ir=1.
  - OP_ADDR: inc_pc=1, halt=(opcode==HLT).
  - OP_FETCH: rd=ALUOP.
  - ALU_OP: rd=ALUOP, ld_ac=ALUOP, inc_pc=(SKZ & zero), ld_pc=JMP, data_e=STO.
  - STORE: rd=ALUOP, ld_ac=ALUOP, ld_pc=JMP, wr=STO, data_e=STO.
- HLT handling:
  - On the rising edge that ends OP_ADDR with opcode==HLT, HALTED is set and `phase` freezes at OP_ADDR.
  - While HALTED: halt=1, sel=0, and every other strobe, including inc_pc, is forced to 0.
- HALTED clears only on reset, or on `step` when `VERIRISC_CTRL_STEP_EN` is defined.
- `opcode` and `zero` are sampled only through the combinational decode; no input is registered.

## Timing
- Reset (`rst_`=0, asynchronous): `phase`=0 and HALTED=0 immediately.
  - Resulting outputs: sel=1, all other strobes 0, halt=0.
  - Reset asserted mid-instruction aborts it at once, with no further strobe.
- After reset deassertion, the first rising edge moves to INST_FETCH. One instruction takes exactly 8 cycles.
- inc_pc in OP_ADDR is a single-cycle pulse.
  - For HLT, that pulse still fires in OP_ADDR, so the PC already points to the next instruction when halted.
- SKZ with zero=1 issues a second inc_pc in ALU_OP, skipping one instruction.
- JMP holds ld_pc for 2 cycles (ALU_OP and STORE).
- STO holds data_e for 2 cycles and wr for 1 cycle (STORE only). data_e precedes wr by one cycle.
- Opcode changes are seen in the same cycle, because the decode is combinational. The IR is stable from IDLE onward.

## Configuration
- Macro: `VERIRISC_CTRL_STEP_EN`.
- Defined:
  - The `step` port exists.
  - `step` is sampled on the rising edge while HALTED=1. If `step`=1, HALTED clears and `phase` loads INST_ADDR, so execution resumes at the next instruction.
  - `step` is ignored while not halted.
  - If reset and `step` are asserted together, reset wins.
- Undefined: no `step` port; HALTED exits only via reset.

## Test plan
- Reset: drive `rst_`=0 mid-STORE with opcode=STO -> phase=0, sel=1, wr=0, data_e=0 in the same cycle, with no clock edge required.
- LDA (opcode=5): over 8 cycles from reset release -> sel=1 in phases 0-3; rd=1 in phases 1-3 and 5-7; ld_ir=1 in phases 2-3; inc_pc=1 in phase 4; ld_ac=1 in phases 6-7; phase wraps 7->0.
- SKZ (opcode=1): with zero=1 -> inc_pc=1 in phases 4 and 6. With zero=0 -> inc_pc=1 in phase 4 only; rd=0 in phases 5-7.
- JMP (opcode=7) -> ld_pc=1 in phases 6 and 7, ld_ac=0. STO (opcode=6) -> data_e=1 in phases 6-7, wr=1 in phase 7 only.
- HLT (opcode=0): -> halt=1 and inc_pc=1 in phase 4. After the next edge -> phase stays 4, halt=1, inc_pc=0, sel=0. This holds for 20 further cycles.
- With `VERIRISC_CTRL_STEP_EN`: while halted, pulse `step`=1 for one cycle -> next phase=0, halt=0, sel=1. A `step` pulse while running leaves the phase sequence unchanged.

Source files
------------

// File: rtl/veririsc_controller.sv
// veririsc_controller: 8-phase VeriRISC sequencer decoding phase/opcode/zero into datapath strobes (optional single-step via VERIRISC_CTRL_STEP_EN)
module veririsc_controller (
    input  logic       clk,
    input  logic       rst_,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef VERIRISC_CTRL_STEP_EN
    input  logic       step,
`endif
    output logic       sel,
    output logic       rd,
    output logic       ld_ir,
    output logic       inc_pc,
    output logic       ld_pc,
    output logic       ld_ac,
    output logic       data_e,
    output logic       wr,
    output logic       halt,
    output logic [2:0] phase
);
    typedef enum logic [2:0] {
        INST_ADDR, INST_FETCH, INST_LOAD, IDLE, OP_ADDR, OP_FETCH, ALU_OP, STORE
    } state_t;
    localparam logic [2:0] HLT = 3'd0, SKZ = 3'd1, STO = 3'd6, JMP = 3'd7;
    state_t state;
    logic   halted;
    logic   run;
    logic   alu;
    logic   late;
    // phase sequencer with HLT freeze; halted only exits via reset or step
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
        end else if (halted) begin
`ifdef VERIRISC_CTRL_STEP_EN
            if (step) begin
                halted <= 1'b0;
                state  <= INST_ADDR;
            end
`endif
        end else if (state == OP_ADDR && opcode == HLT) begin
            halted <= 1'b1;
        end else begin
            state <= state_t'(state + 3'd1);
        end
    end
    assign run    = !halted;
    assign alu    = opcode inside {[3'd2:3'd5]};
    assign late   = state == ALU_OP || state == STORE;
    assign phase  = state;
    assign sel    = run && state inside {INST_ADDR, INST_FETCH, INST_LOAD, IDLE};
    assign rd     = run && (state inside {INST_FETCH, INST_LOAD, IDLE} || (state inside {OP_FETCH, ALU_OP, STORE} && alu));
    assign ld_ir  = run && state inside {INST_LOAD, IDLE};
    assign inc_pc = run && (state == OP_ADDR || (state == ALU_OP && opcode == SKZ && zero));
    assign ld_pc  = run && late && opcode == JMP;
    assign ld_ac  = run && late && alu;
    assign data_e = run && late && opcode == STO;
    assign wr     = run && state == STORE && opcode == STO;
    assign halt   = halted || (state == OP_ADDR && opcode == HLT);
endmodule

// File: tb/tb_veririsc_controller.sv
// tb_veririsc_controller: randomized self-checking bench against an instruction-cycle table model
module tb_veririsc_controller;
`ifdef VERIRISC_CTRL_STEP_EN
    localparam bit STEP_EN = 1'b1;
`else
    localparam bit STEP_EN = 1'b0;
`endif
    logic       clk = 1'b0;
    logic       rst_ = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       zero = 1'b0;
    logic       step = 1'b0;
    logic       sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt;
    logic [2:0] phase;
    logic [11:0] outs;
    int         n_chk = 0;
    int         n_fail = 0;
    int         m_ph = 0;
    bit         m_h = 1'b0;

    veririsc_controller dut (
        .clk(clk),
        .rst_(rst_),
        .opcode(opcode),
        .zero(zero),
`ifdef VERIRISC_CTRL_STEP_EN
        .step(step),
`endif
        .sel(sel),
        .rd(rd),
        .ld_ir(ld_ir),
        .inc_pc(inc_pc),
        .ld_pc(ld_pc),
        .ld_ac(ld_ac),
        .data_e(data_e),
        .wr(wr),
        .halt(halt),
        .phase(phase)
    );

    always #5 clk = ~clk;

    assign outs = {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt};

    // reference model: instruction position counter and halted flag
    always @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            m_ph <= 0;
            m_h  <= 1'b0;
        end else if (m_h) begin
            if (STEP_EN && step) begin
                m_h  <= 1'b0;
                m_ph <= 0;
            end
        end else if (m_ph == 4 && opcode == 3'd0) begin
            m_h <= 1'b1;
        end else begin
            m_ph <= (m_ph + 1) % 8;
        end
    end

    // strobe table per phase: {phase, sel, rd, ld_ir, inc_pc, ld_pc, ld_ac, data_e, wr, halt}
    function automatic logic [11:0] model_out(int ph, bit h, logic [2:0] op, logic z);
        bit a   = (op == 3'd2) || (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
        bit jmp = (op == 3'd7);
        bit sto = (op == 3'd6);
        logic [2:0] p = 3'(ph);
        if (h) return {p, 9'b0_0000_0001};
        case (ph)
            0: return {p, 9'b1_0000_0000};
            1: return {p, 9'b1_1000_0000};
            2, 3: return {p, 9'b1_1100_0000};
            4: return {p, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, op == 3'd0};
            5: return {p, 1'b0, a, 7'b0};
            6: return {p, 1'b0, a, 1'b0, (op == 3'd1) && z, jmp, a, sto, 1'b0, 1'b0};
            default: return {p, 1'b0, a, 1'b0, 1'b0, jmp, a, sto, sto, 1'b0};
        endcase
    endfunction

    task automatic drive(input logic [2:0] op, input logic z, input logic st);
        @(negedge clk);
        opcode = op;
        zero   = z;
        step   = st;
        #1;
    endtask

    task automatic reset_dut;
        @(negedge clk);
        rst_ = 1'b0;
        #1;
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic test_reset;
        #3;
        n_chk++;
        if (outs !== 12'b000_1_0000_0000) begin
            n_fail++;
            $display("FAIL reset_state got=%b exp=%b", outs, 12'b000_1_0000_0000);
        end
        @(negedge clk);
        rst_ = 1'b1;
        #1;
        n_chk++;
        if (outs !== model_out(m_ph, m_h, opcode, zero)) begin
            n_fail++;
            $display("FAIL reset_release got=%b exp=%b", outs, model_out(m_ph, m_h, opcode, zero));
        end
    endtask

    task automatic test_opcode(input logic [2:0] op, input logic z, input string name);
        reset_dut();
        for (int i = 0; i < 16; i++) begin
            drive(op, z, 1'b0);
            n_chk++;
            if (outs !== model_out(m_ph, m_h, opcode, zero)) begin
                n_fail++;
                $display("FAIL %s cyc=%0d got=%b exp=%b", name, i, outs, model_out(m_ph, m_h, opcode, zero));
            end
        end
    endtask

    task automatic test_async_reset;
        reset_dut();
        for (int i = 0; i < 20 && !(m_ph == 7); i++) drive(3'd6, 1'b0, 1'b0);
        n_chk++;
        if (wr !== 1'b1 || phase !== 3'd7) begin
            n_fail++;
            $display("FAIL pre_reset_store phase=%0d wr=%b exp phase=7 wr=1", phase, wr);
        end
        #2;
        rst_ = 1'b0;
        #1;
        n_chk++;
        if (phase !== 3'd0 || sel !== 1'b1 || wr !== 1'b0 || data_e !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset phase=%0d sel=%b wr=%b data_e=%b exp 0/1/0/0", phase, sel, wr, data_e);
        end
        @(negedge clk);
        rst_ = 1'b1;
    endtask

    task automatic test_random;
        reset_dut();
        for (int i = 0; i < 400; i++) begin
            drive(3'($urandom_range(1, 7)), 1'($urandom), 1'($urandom));
            n_chk++;
            if (outs !== model_out(m_ph, m_h, opcode, zero)) begin
                n_fail++;
                $display("FAIL random cyc=%0d op=%0d z=%b got=%b exp=%b", i, opcode, zero, outs, model_out(m_ph, m_h, opcode, zero));
            end
        end
    endtask

    task automatic test_hlt;
        reset_dut();
        for (int i = 0; i < 25; i++) begin
            drive(3'd0, 1'($urandom), 1'b0);
            n_chk++;
            if (outs !== model_out(m_ph, m_h, opcode, zero)) begin
                n_fail++;
                $display("FAIL hlt cyc=%0d got=%b exp=%b", i, outs, model_out(m_ph, m_h, opcode, zero));
            end
        end
        for (int i = 0; i < 5; i++) begin
            drive(3'($urandom_range(0, 7)), 1'($urandom), 1'b0);
            n_chk++;
            if (phase !== 3'd4 || halt !== 1'b1 || sel !== 1'b0 || inc_pc !== 1'b0 || rd !== 1'b0) begin
                n_fail++;
                $display("FAIL halted_hold phase=%0d halt=%b sel=%b inc_pc=%b rd=%b exp 4/1/0/0/0", phase, halt, sel, inc_pc, rd);
            end
        end
    endtask

    task automatic test_step;
        drive(3'd0, 1'b0, 1'b1);
        n_chk++;
        if (outs !== model_out(m_ph, m_h, opcode, zero)) begin
            n_fail++;
            $display("FAIL step_pulse got=%b exp=%b", outs, model_out(m_ph, m_h, opcode, zero));
        end
        for (int i = 0; i < 10; i++) begin
            drive(3'($urandom_range(1, 7)), 1'($urandom), 1'b0);
            n_chk++;
            if (outs !== model_out(m_ph, m_h, opcode, zero)) begin
                n_fail++;
                $display("FAIL step_resume cyc=%0d got=%b exp=%b", i, outs, model_out(m_ph, m_h, opcode, zero));
            end
        end
    endtask

    initial begin
        test_reset();
        test_opcode(3'd5, 1'b0, "lda");
        test_opcode(3'd1, 1'b1, "skz_z1");
        test_opcode(3'd1, 1'b0, "skz_z0");
        test_opcode(3'd7, 1'b1, "jmp");
        test_opcode(3'd6, 1'b0, "sto");
        test_opcode(3'd2, 1'b1, "add");
        test_async_reset();
        test_random();
        test_hlt();
        test_step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
